psum_sfu: RTL and testbench

PSUM_SFU -- requirements
Module: psum_sfu

---
 rtl/psum_sfu.sv | 91 +++++++++
 tb/tb_psum_sfu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/psum_sfu.sv
// psum_sfu: drains OFIFO rows, optionally adds the old psum from SRAM,
// saturates and ReLUs each lane, and writes the row back to psum SRAM.
module psum_sfu #(
    parameter int col = 8,
    parameter int psum_bw = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [10:0]            n_out,
    input  logic [10:0]            base_addr,
    input  logic                   acc_en,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic [10:0]            A_pmem,
    output logic                   CEN_pmem,
    output logic                   WEN_pmem,
    output logic [col*psum_bw-1:0] D_pmem,
    input  logic [col*psum_bw-1:0] Q_pmem,
    output logic                   busy,
    output logic                   done
);
    localparam int W = col * psum_bw;
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
    state_t       r_state;
    logic [10:0]  r_idx, r_n, r_base;
    logic         r_acc, r_relu;
    logic [W-1:0] r_data, r_result, w_result;
    logic [10:0]  w_addr;
    logic         w_rd;
    // 11-bit add wraps the address from 2047 back to 0 for free
    assign w_addr   = r_base + r_idx;
    assign w_rd     = r_state == READ && ofifo_valid;
    assign ofifo_rd = w_rd;
    assign CEN_pmem = !((w_rd && r_acc) || r_state == WRITE);
    assign WEN_pmem = r_state != WRITE;
    assign A_pmem   = (r_state == READ || r_state == WRITE) ? w_addr : '0;
    assign D_pmem   = r_state == WRITE ? r_result : '0;
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;
    for (genvar g = 0; g < col; g++) begin : g_lane
        logic [psum_bw-1:0] w_a, w_b, w_sat;
        logic [psum_bw:0]   w_sum;
        assign w_a   = r_data[g*psum_bw +: psum_bw];
        assign w_b   = r_acc ? Q_pmem[g*psum_bw +: psum_bw] : '0;
        assign w_sum = {w_a[psum_bw-1], w_a} + {w_b[psum_bw-1], w_b};
        // overflow iff the two top bits of the widened sum disagree
        assign w_sat = (w_sum[psum_bw] == w_sum[psum_bw-1]) ? w_sum[psum_bw-1:0]
                     : {w_sum[psum_bw], {(psum_bw-1){~w_sum[psum_bw]}}};
        assign w_result[g*psum_bw +: psum_bw] = (r_relu && w_sat[psum_bw-1]) ? '0 : w_sat;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_n      <= '0;
            r_base   <= '0;
            r_acc    <= 1'b0;
            r_relu   <= 1'b0;
            r_data   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_n     <= n_out;
                    r_base  <= base_addr;
                    r_acc   <= acc_en;
                    r_relu  <= relu_en;
                    r_idx   <= '0;
                    r_state <= n_out != '0 ? READ : DONE;
                end
                READ: if (ofifo_valid) begin
                    r_data  <= ofifo_out;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_result <= w_result;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    r_idx   <= r_idx == r_n - 11'd1 ? r_idx : r_idx + 11'd1;
                    r_state <= r_idx == r_n - 11'd1 ? DONE : READ;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_sfu.sv
// tb_psum_sfu: drives psum_sfu with an OFIFO queue and an SRAM array, and
// compares every write-back against a lane-wise arithmetic reference.
module tb_psum_sfu;
    localparam int COL = 8, PB = 16, W = COL * PB;
    logic clk = 0, reset = 1, start = 0, acc_en = 0, relu_en = 0, ofifo_valid = 0;
    logic [10:0] n_out = '0, base_addr = '0, A_pmem;
    logic [W-1:0] ofifo_out = '0, Q_pmem = '0, D_pmem;
    logic ofifo_rd, CEN_pmem, WEN_pmem, busy, done;
    typedef struct {logic [10:0] a; logic [W-1:0] d;} wr_t;
    wr_t exp_q[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] mem [2048];
    int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0, acc_cnt = 0;
    int first_wr = -1, done_cyc = -1, c0 = 0, d0 = 0, a0 = 0;
    bit hold_low = 0, rnd_gate = 0;

    always #5 clk = ~clk;

    psum_sfu #(.col(COL), .psum_bw(PB)) dut (
        .clk(clk), .reset(reset), .start(start), .n_out(n_out), .base_addr(base_addr),
        .acc_en(acc_en), .relu_en(relu_en), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
        .ofifo_rd(ofifo_rd), .A_pmem(A_pmem), .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem),
        .D_pmem(D_pmem), .Q_pmem(Q_pmem), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] nw, old, input bit acc, relu);
        logic [W-1:0] r;
        int s;
        for (int l = 0; l < COL; l++) begin
            s = int'($signed(nw[l*PB +: PB])) + (acc ? int'($signed(old[l*PB +: PB])) : 0);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (relu && s < 0) s = 0;
            r[l*PB +: PB] = s[PB-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int l = 0; l < COL; l++)
            case ($urandom_range(0, 3))
                0: r[l*PB +: PB] = 16'h7F00 | 16'($urandom_range(0, 255));
                1: r[l*PB +: PB] = 16'h8000 | 16'($urandom_range(0, 255));
                default: r[l*PB +: PB] = 16'($urandom);
            endcase
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ofifo_rd && fq.size() > 0) void'(fq.pop_front());
        if (!CEN_pmem && WEN_pmem) Q_pmem <= mem[A_pmem];
    end

    always @(posedge clk) begin
        #1;
        ofifo_valid = !hold_low && fq.size() > 0 && (!rnd_gate || $urandom_range(0, 3) != 0);
        ofifo_out = fq.size() > 0 ? fq[0] : '0;
    end

    always @(negedge clk) if (!reset) begin
        if (!CEN_pmem) acc_cnt++;
        if (!CEN_pmem && !WEN_pmem) begin
            mem[A_pmem] = D_pmem;
            if (first_wr < 0) first_wr = cyc;
            chk("write_expected", W'(exp_q.size() > 0), W'(1));
            if (exp_q.size() > 0) begin
                chk("waddr", W'(A_pmem), W'(exp_q[0].a));
                chk("wdata", D_pmem, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic launch(input int n, base, input bit acc, relu, dir, input int nv, ov);
        logic [W-1:0] row;
        logic [10:0] a;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            a = 11'((base + i) % 2048);
            row = dir ? {COL{nv[PB-1:0]}} : rand_row();
            if (dir) mem[a] = {COL{ov[PB-1:0]}};
            fq.push_back(row);
            exp_q.push_back('{a, model(row, mem[a], acc, relu)});
        end
        n_out = 11'(n); base_addr = 11'(base); acc_en = acc; relu_en = relu; start = 1;
        c0 = cyc + 1; d0 = done_cnt; a0 = acc_cnt; first_wr = -1;
        @(negedge clk);
        start = 0; n_out = 11'($urandom); base_addr = 11'($urandom);
        acc_en = 1'($urandom); relu_en = 1'($urandom);
    endtask

    task automatic finish(input int n, input bit timed);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done_seen", W'(done_cnt != d0), W'(1));
        repeat (3) @(negedge clk);
        #1;
        chk("done_once", W'(done_cnt - d0), W'(1));
        chk("writes_left", W'(exp_q.size()), W'(0));
        if (timed) chk("done_cycle", W'(done_cyc - c0), W'(3 * n));
        if (timed && n > 0) chk("first_write", W'(first_wr - c0), W'(2));
        if (n == 0) chk("no_access", W'(acc_cnt - a0), W'(0));
        exp_q.delete();
        fq.delete();
    endtask

    initial begin
        int n, b;
        bit rg;
        for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("rst_rd", W'(ofifo_rd), W'(0));
        chk("rst_cen", W'(CEN_pmem), W'(1));
        chk("rst_wen", W'(WEN_pmem), W'(1));
        chk("rst_addr", W'(A_pmem), W'(0));
        chk("rst_data", D_pmem, W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        reset = 0;
        launch(2, 10, 0, 0, 1, 5, 0);            finish(2, 1);
        launch(1, 100, 1, 0, 1, 1000, 32000);    finish(1, 1);
        launch(1, 101, 1, 0, 1, -1000, -32000);  finish(1, 1);
        launch(1, 102, 1, 1, 1, 3, -7);          finish(1, 1);
        launch(1, 103, 1, 1, 1, 3, 7);           finish(1, 1);
        launch(2, 2047, 1, 0, 0, 0, 0);          finish(2, 1);
        hold_low = 1;
        launch(1, 300, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_rd", W'(ofifo_rd), W'(0));
            chk("stall_cen", W'(CEN_pmem), W'(1));
            start = i == 1; n_out = 11'd5; base_addr = 11'd700;
            @(negedge clk);
        end
        start = 0;
        hold_low = 0;
        finish(1, 0);
        launch(0, 50, 1, 0, 0, 0, 0);            finish(0, 1);
        launch(3, 400, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_cen", W'(CEN_pmem), W'(1));
        chk("abort_done", W'(done), W'(0));
        reset = 0;
        a0 = acc_cnt; d0 = done_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_access", W'(acc_cnt - a0), W'(0));
        chk("abort_no_done", W'(done_cnt - d0), W'(0));
        exp_q.delete();
        fq.delete();
        repeat (12) begin
            n = $urandom_range(1, 6);
            b = $urandom_range(0, 3) == 0 ? $urandom_range(2042, 2047) : $urandom_range(0, 2047);
            rg = 1'($urandom);
            rnd_gate = rg;
            launch(n, b, 1'($urandom), 1'($urandom), 0, 0, 0);
            finish(n, !rg);
            rnd_gate = 0;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
